// File: rtl/inst_fetch_queue.sv
// Fetch front end: PC register, credit-limited imem requests, in-flight PC tags and a {pc, inst} queue.
// Optional IFQ_BYPASS_EN forwards a response to decode in the same cycle when the queue is empty.
module inst_fetch_queue #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            Clk,
    input  logic            Rst_N,
    input  logic            in_redirect_valid,
    input  logic [XLEN-1:0] in_redirect_pc,
    output logic            out_imem_req_valid,
    input  logic            in_imem_req_ready,
    output logic [XLEN-1:0] out_imem_addr,
    input  logic            in_imem_rsp_valid,
    input  logic [31:0]     in_imem_rsp_data,
    output logic            out_inst_valid,
    input  logic            in_inst_ready,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] out_inst_pc
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [XLEN-1:0]   ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0]   PC_STEP    = XLEN'(4);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] q_wr_ptr_q, q_wr_ptr_d, q_rd_ptr_q, q_rd_ptr_d;
    logic [PTR_W-1:0] tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;

    logic [31:0]      q_inst_mem [DEPTH];
    logic [XLEN-1:0]  q_pc_mem   [DEPTH];
    logic [XLEN-1:0]  tag_mem    [DEPTH];

    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] used_slots;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_accept;
    logic             rsp_run;
    logic             head_valid;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  rsp_tag;

    // Only one of outstanding/drop_cnt is ever non-zero, so their sum is the live in-flight count.
    assign in_flight  = outstanding_q + drop_cnt_q;
    assign used_slots = outstanding_q + count_q;
    assign req_valid  = Rst_N && (state_q == ST_RUN) && (used_slots < DEPTH_C);
    assign req_fire   = req_valid && in_imem_req_ready;
    assign rsp_accept = in_imem_rsp_valid && (in_flight != '0);
    assign rsp_run    = rsp_accept && (state_q == ST_RUN);
    assign rsp_tag    = tag_mem[tag_rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && in_inst_ready;

    assign out_imem_req_valid = req_valid;
    assign out_imem_addr      = pc_q;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    assign bypass         = !head_valid && rsp_run && !in_redirect_valid;
    assign push           = rsp_run && !in_redirect_valid && !(bypass && in_inst_ready);
    assign out_inst_valid = head_valid || bypass;
    assign out_inst       = head_valid ? q_inst_mem[q_rd_ptr_q] :
                            bypass     ? in_imem_rsp_data       : '0;
    assign out_inst_pc    = head_valid ? q_pc_mem[q_rd_ptr_q]   :
                            bypass     ? rsp_tag                : '0;
`else
    assign push           = rsp_run && !in_redirect_valid;
    assign out_inst_valid = head_valid;
    assign out_inst       = head_valid ? q_inst_mem[q_rd_ptr_q] : '0;
    assign out_inst_pc    = head_valid ? q_pc_mem[q_rd_ptr_q]   : '0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        q_wr_ptr_d    = q_wr_ptr_q;
        q_rd_ptr_d    = q_rd_ptr_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;

        if (in_redirect_valid) begin
            // A request accepted now is already stale; a response arriving now is dropped here.
            pc_d          = in_redirect_pc & ALIGN_MASK;
            drop_cnt_d    = in_flight + CNT_W'(req_fire) - CNT_W'(rsp_accept);
            outstanding_d = '0;
            count_d       = '0;
            q_wr_ptr_d    = '0;
            q_rd_ptr_d    = '0;
            tag_wr_ptr_d  = '0;
            tag_rd_ptr_d  = '0;
            state_d       = (drop_cnt_d != '0) ? ST_FLUSH : ST_RUN;
        end else begin
            if (req_fire) begin
                pc_d         = pc_q + PC_STEP;
                tag_wr_ptr_d = tag_wr_ptr_q + PTR_W'(1);
            end
            if (rsp_run) begin
                tag_rd_ptr_d = tag_rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                q_wr_ptr_d = q_wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                q_rd_ptr_d = q_rd_ptr_q + PTR_W'(1);
            end
            outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_run);
            count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
            if ((state_q == ST_FLUSH) && rsp_accept) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
                if (drop_cnt_q == CNT_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            q_wr_ptr_q    <= '0;
            q_rd_ptr_q    <= '0;
            tag_wr_ptr_q  <= '0;
            tag_rd_ptr_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            q_wr_ptr_q    <= q_wr_ptr_d;
            q_rd_ptr_q    <= q_rd_ptr_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
        end
    end

    // NOTE: storage arrays are not reset; occupancy counters alone decide which entries are valid.
    always_ff @(posedge Clk) begin
        if (req_fire && !in_redirect_valid) begin
            tag_mem[tag_wr_ptr_q] <= pc_q;
        end
        if (push) begin
            q_inst_mem[q_wr_ptr_q] <= in_imem_rsp_data;
            q_pc_mem[q_wr_ptr_q]   <= rsp_tag;
        end
    end

endmodule
